// File: rtl/filter_rr_scheduler.sv
// Round-robin front end and tag-routed back end that time-share one Filter pipeline; results return LATENCY cycles after issue.
// No backpressure from the Filter: at most one grant per cycle, requesters are throttled only by ready.
`timescale 1ns/1ps
module filter_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int TAGW    = 2,
  parameter int LATENCY = 2,
  parameter int WIDTH   = 16,
  localparam int CNTW   = $clog2(LATENCY + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    io_enable,
  input  logic                    io_flush,
  input  logic [NREQ*WIDTH-1:0]   io_req_data,
  input  logic [NREQ-1:0]         io_req_parity,
  input  logic [NREQ-1:0]         io_req_valid,
  output logic [NREQ-1:0]         io_req_ready,
  output logic [WIDTH-1:0]        io_f_x_data,
  output logic                    io_f_x_valid,
  output logic                    io_f_x_parity,
  input  logic [WIDTH-1:0]        io_f_y_data,
  input  logic                    io_f_y_valid,
  input  logic                    io_f_y_parity,
  output logic [WIDTH-1:0]        io_rsp_data,
  output logic                    io_rsp_parity,
  output logic [NREQ-1:0]         io_rsp_valid,
  output logic [CNTW-1:0]         io_inflight,
  output logic                    io_flush_done,
  output logic                    io_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state;
  logic [TAGW-1:0]   ptr;
  logic [TAGW-1:0]   cand;
  logic [TAGW-1:0]   gnt_idx;
  logic              gnt_found;
  logic              xfer;
  logic [LATENCY-1:0] tag_v;
  logic [TAGW-1:0]   tag_q [LATENCY];
  // Filter registers are unreset, so y_valid is only trusted once LATENCY post-reset cycles have flowed through.
  logic [LATENCY-1:0] chk;
  logic              tail_v;
  logic [TAGW-1:0]   tail_tag;
  logic [CNTW-1:0]   inflight_nxt;

  always_comb begin
    cand      = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = TAGW'((int'(ptr) + k) % NREQ);
      if (!gnt_found && io_req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign xfer         = (state == RUN) && gnt_found;
  assign io_f_x_valid = xfer;

  always_comb begin
    io_req_ready  = '0;
    io_f_x_data   = '0;
    io_f_x_parity = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (xfer && gnt_idx == TAGW'(i)) begin
        io_req_ready[i] = 1'b1;
        io_f_x_data     = io_req_data[i*WIDTH +: WIDTH];
        io_f_x_parity   = io_req_parity[i];
      end
    end
  end

  assign tail_v   = tag_v[LATENCY-1];
  assign tail_tag = tag_q[LATENCY-1];

  always_comb begin
    io_rsp_valid  = '0;
    io_rsp_data   = tail_v ? io_f_y_data : '0;
    io_rsp_parity = tail_v ? io_f_y_parity : 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (tail_v && tail_tag == TAGW'(i)) io_rsp_valid[i] = 1'b1;
    end
  end

  always_comb begin
    inflight_nxt = io_inflight;
    if (xfer && !tail_v)      inflight_nxt = io_inflight + CNTW'(1);
    else if (!xfer && tail_v) inflight_nxt = io_inflight - CNTW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      ptr           <= TAGW'(NREQ - 1);
      tag_v         <= '0;
      chk           <= '0;
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
      io_inflight   <= '0;
      io_flush_done <= 1'b0;
      io_err        <= 1'b0;
    end else begin
      if (xfer) ptr <= gnt_idx;
      tag_v[0] <= xfer;
      tag_q[0] <= gnt_idx;
      chk[0]   <= 1'b1;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_q[i] <= tag_q[i-1];
        chk[i]   <= chk[i-1];
      end
      io_inflight <= inflight_nxt;
      if (chk[LATENCY-1] && (io_f_y_valid != tail_v)) io_err <= 1'b1;

      // flush_done is raised in the same cycle inflight first reads zero; the exit follows one cycle later.
      io_flush_done <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (io_flush) begin
            state         <= DRAIN;
            io_flush_done <= (inflight_nxt == '0);
          end else if (state == IDLE && io_enable) begin
            state <= RUN;
          end else if (state == RUN && !io_enable) begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (io_flush || io_inflight != '0) io_flush_done <= (inflight_nxt == '0);
          else                               state <= io_enable ? RUN : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_rr_scheduler.sv
// Scoreboard bench for filter_rr_scheduler with a behavioural unreset Filter pipeline on the x/y side.
`timescale 1ns/1ps
module tb_filter_rr_scheduler;

  localparam int NREQ    = 4;
  localparam int TAGW    = 2;
  localparam int LATENCY = 2;
  localparam int WIDTH   = 16;
  localparam int CNTW    = $clog2(LATENCY + 1);

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  io_enable = 1'b0;
  logic                  io_flush = 1'b0;
  logic [NREQ*WIDTH-1:0] io_req_data = '0;
  logic [NREQ-1:0]       io_req_parity = '0;
  logic [NREQ-1:0]       io_req_valid = '0;
  logic [NREQ-1:0]       io_req_ready;
  logic [WIDTH-1:0]      io_f_x_data;
  logic                  io_f_x_valid;
  logic                  io_f_x_parity;
  logic [WIDTH-1:0]      io_f_y_data;
  logic                  io_f_y_valid;
  logic                  io_f_y_parity;
  logic [WIDTH-1:0]      io_rsp_data;
  logic                  io_rsp_parity;
  logic [NREQ-1:0]       io_rsp_valid;
  logic [CNTW-1:0]       io_inflight;
  logic                  io_flush_done;
  logic                  io_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  filter_rr_scheduler #(.NREQ(NREQ), .TAGW(TAGW), .LATENCY(LATENCY), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .io_enable(io_enable), .io_flush(io_flush),
    .io_req_data(io_req_data), .io_req_parity(io_req_parity), .io_req_valid(io_req_valid),
    .io_req_ready(io_req_ready), .io_f_x_data(io_f_x_data), .io_f_x_valid(io_f_x_valid),
    .io_f_x_parity(io_f_x_parity), .io_f_y_data(io_f_y_data), .io_f_y_valid(io_f_y_valid),
    .io_f_y_parity(io_f_y_parity), .io_rsp_data(io_rsp_data), .io_rsp_parity(io_rsp_parity),
    .io_rsp_valid(io_rsp_valid), .io_inflight(io_inflight), .io_flush_done(io_flush_done),
    .io_err(io_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WIDTH-1:0] filt_d(input logic [WIDTH-1:0] x);
    return {x[7:0], x[15:8]} ^ 16'hA5C3;
  endfunction

  // Behavioural Filter: unreset LATENCY-stage pipeline.
  logic [WIDTH-1:0] fd [LATENCY];
  logic             fp [LATENCY];
  logic             fv [LATENCY];
  logic             force_yv = 1'b0;

  always @(posedge clk) begin
    fv[0] <= io_f_x_valid;
    fd[0] <= filt_d(io_f_x_data);
    fp[0] <= io_f_x_parity ^ io_f_x_data[0];
    for (int i = 1; i < LATENCY; i++) begin
      fv[i] <= fv[i-1];
      fd[i] <= fd[i-1];
      fp[i] <= fp[i-1];
    end
  end
  assign io_f_y_valid  = fv[LATENCY-1] | force_yv;
  assign io_f_y_data   = fd[LATENCY-1];
  assign io_f_y_parity = fp[LATENCY-1];

  typedef struct {
    int               owner;
    logic [WIDTH-1:0] d;
    logic             p;
    int               due;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  // Monitor: checks each handshake on the x side and pushes the expected result, pops on every response.
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
    end else begin
      n_checks++;
      if ((io_req_ready & ~io_req_valid) != '0 || $countones(io_req_ready) > 1) begin
        n_fail++;
        $display("FAIL mon_ready_legal: ready=%b valid=%b (need one-hot subset of valid)", io_req_ready, io_req_valid);
      end
      n_checks++;
      if (io_f_x_valid !== (|(io_req_ready & io_req_valid))) begin
        n_fail++;
        $display("FAIL mon_x_valid: got %b want %b", io_f_x_valid, |(io_req_ready & io_req_valid));
      end
      if (io_rsp_valid != '0) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL mon_rsp_unexpected: rsp_valid=%b with empty scoreboard at cycle %0d", io_rsp_valid, cyc);
        end else begin
          e = sb.pop_front();
          if (io_rsp_valid !== (NREQ'(1) << e.owner) || io_rsp_data !== e.d ||
              io_rsp_parity !== e.p || cyc != e.due) begin
            n_fail++;
            $display("FAIL mon_rsp: got owner=%b data=%h par=%b cyc=%0d want owner=%b data=%h par=%b cyc=%0d",
                     io_rsp_valid, io_rsp_data, io_rsp_parity, cyc,
                     NREQ'(1) << e.owner, e.d, e.p, e.due);
          end
        end
      end else begin
        n_checks++;
        if (io_rsp_data !== '0 || io_rsp_parity !== 1'b0) begin
          n_fail++;
          $display("FAIL mon_rsp_zero: data=%h par=%b want 0 with no valid", io_rsp_data, io_rsp_parity);
        end
        if (sb.size() != 0 && sb[0].due <= cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL mon_rsp_missing: no response at cycle %0d, want owner %0d due %0d", cyc, sb[0].owner, sb[0].due);
          void'(sb.pop_front());
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (io_req_ready[i] && io_req_valid[i]) begin
          n_checks++;
          if (io_f_x_data !== io_req_data[i*WIDTH +: WIDTH] || io_f_x_parity !== io_req_parity[i]) begin
            n_fail++;
            $display("FAIL mon_x_data: got %h/%b want %h/%b", io_f_x_data, io_f_x_parity,
                     io_req_data[i*WIDTH +: WIDTH], io_req_parity[i]);
          end
          sb.push_back('{i, filt_d(io_req_data[i*WIDTH +: WIDTH]),
                         io_req_parity[i] ^ io_req_data[i*WIDTH], cyc + LATENCY});
        end
      end
    end
  end

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (io_req_ready !== '0 || io_f_x_valid !== 1'b0 || io_f_x_data !== '0) begin
      n_fail++;
      $display("FAIL reset_front: ready=%b xv=%b xd=%h want 0", io_req_ready, io_f_x_valid, io_f_x_data);
    end
    n_checks++;
    if (io_rsp_valid !== '0 || io_rsp_data !== '0 || io_rsp_parity !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_back: rv=%b rd=%h rp=%b want 0", io_rsp_valid, io_rsp_data, io_rsp_parity);
    end
    n_checks++;
    if (io_inflight !== '0 || io_flush_done !== 1'b0 || io_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: inflight=%0d done=%b err=%b want 0", io_inflight, io_flush_done, io_err);
    end
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_single;
    logic [CNTW-1:0]  exp_inf [5];
    logic [NREQ-1:0]  exp_rv  [5];
    logic [WIDTH-1:0] exp_rd  [5];
    exp_inf = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd0};
    exp_rv  = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
    exp_rd  = '{16'h0000, 16'h0000, 16'hA443, 16'h91D1, 16'h0000};
    @(posedge clk); #1 io_enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      io_req_valid = (k < 2) ? 4'b0001 : 4'b0000;
      io_req_data[15:0] = (k == 0) ? 16'h8001 : 16'h1234;
      io_req_parity[0]  = (k == 0);
      @(negedge clk);
      n_checks++;
      if (io_req_ready !== ((k < 2) ? 4'b0001 : 4'b0000)) begin
        n_fail++;
        $display("FAIL single_ready[%0d]: got %b want %b", k, io_req_ready, (k < 2) ? 4'b0001 : 4'b0000);
      end
      n_checks++;
      if (io_inflight !== exp_inf[k]) begin
        n_fail++;
        $display("FAIL single_inflight[%0d]: got %0d want %0d", k, io_inflight, exp_inf[k]);
      end
      n_checks++;
      if (io_rsp_valid !== exp_rv[k] || io_rsp_data !== exp_rd[k] || io_rsp_parity !== 1'b0) begin
        n_fail++;
        $display("FAIL single_rsp[%0d]: got %b/%h/%b want %b/%h/0", k, io_rsp_valid, io_rsp_data,
                 io_rsp_parity, exp_rv[k], exp_rd[k]);
      end
    end
  endtask

  task automatic test_all4;
    logic [NREQ-1:0] hist [8];
    logic [NREQ-1:0] exp_r;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      io_req_valid  = 4'b1111;
      io_req_data   = {$urandom(), $urandom()};
      io_req_parity = 4'($urandom());
      @(negedge clk);
      hist[k] = io_req_ready;
      exp_r   = NREQ'(1) << ((1 + k) % NREQ);  // pointer sits on 0 after test_single
      n_checks++;
      if (io_req_ready !== exp_r) begin
        n_fail++;
        $display("FAIL all4_grant[%0d]: got %b want %b", k, io_req_ready, exp_r);
      end
    end
    for (int w = 0; w + 3 < 8; w++) begin
      n_checks++;
      if ((hist[w] | hist[w+1] | hist[w+2] | hist[w+3]) !== 4'b1111) begin
        n_fail++;
        $display("FAIL all4_window[%0d]: union %b want 1111", w, hist[w] | hist[w+1] | hist[w+2] | hist[w+3]);
      end
    end
    @(posedge clk); #1 io_req_valid = '0;
    repeat (LATENCY + 1) @(posedge clk);
  endtask

  task automatic test_sparse;
    logic [NREQ-1:0] exp_r;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      io_req_valid  = 4'b1010;
      io_req_data   = {$urandom(), $urandom()};
      io_req_parity = 4'($urandom());
      @(negedge clk);
      exp_r = (k % 2 == 0) ? 4'b0010 : 4'b1000;
      n_checks++;
      if (io_req_ready !== exp_r) begin
        n_fail++;
        $display("FAIL sparse_grant[%0d]: got %b want %b", k, io_req_ready, exp_r);
      end
    end
    @(posedge clk); #1 io_req_valid = '0;
    repeat (LATENCY + 1) @(posedge clk);
  endtask

  task automatic test_flush;
    logic [NREQ-1:0] exp_rdy [8];
    logic [CNTW-1:0] exp_inf [8];
    exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001};
    exp_inf = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1};
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      io_req_valid  = 4'b1111;
      io_req_data   = {$urandom(), $urandom()};
      io_req_parity = 4'($urandom());
      io_flush      = (k == 2);
      @(negedge clk);
      n_checks++;
      if (io_req_ready !== exp_rdy[k]) begin
        n_fail++;
        $display("FAIL flush_grant[%0d]: got %b want %b", k, io_req_ready, exp_rdy[k]);
      end
      n_checks++;
      if (io_inflight !== exp_inf[k]) begin
        n_fail++;
        $display("FAIL flush_inflight[%0d]: got %0d want %0d", k, io_inflight, exp_inf[k]);
      end
      n_checks++;
      if (io_flush_done !== (k == 5)) begin
        n_fail++;
        $display("FAIL flush_done[%0d]: got %b want %b", k, io_flush_done, k == 5);
      end
    end
    @(posedge clk); #1 io_req_valid = '0;
    repeat (LATENCY + 1) @(posedge clk);
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      io_req_valid  = 4'b1111;
      io_req_data   = {$urandom(), $urandom()};
      io_req_parity = 4'($urandom());
      @(negedge clk);
      n_checks++;
      if (io_req_ready !== (NREQ'(1) << (k + 1))) begin
        n_fail++;
        $display("FAIL rmid_grant[%0d]: got %b want %b", k, io_req_ready, NREQ'(1) << (k + 1));
      end
    end
    @(posedge clk); #1 reset = 1'b0;
    #1;
    n_checks++;
    if (io_req_ready !== '0 || io_f_x_valid !== 1'b0 || io_f_x_data !== '0 || io_rsp_valid !== '0 ||
        io_rsp_data !== '0 || io_inflight !== '0 || io_err !== 1'b0 || io_flush_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_async: rdy=%b xv=%b rv=%b inf=%0d err=%b want all 0",
               io_req_ready, io_f_x_valid, io_rsp_valid, io_inflight, io_err);
    end
    @(posedge clk); #1 reset = 1'b1;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
        io_req_valid = (j == 1) ? 4'b1111 : 4'b0000;
        io_req_data  = {$urandom(), $urandom()};
      end
      @(negedge clk);
      n_checks++;
      if (io_rsp_valid !== '0 || io_err !== 1'b0) begin
        n_fail++;
        $display("FAIL rmid_after[%0d]: rv=%b err=%b want 0/0", j, io_rsp_valid, io_err);
      end
      n_checks++;
      if (io_req_ready !== ((j == 1) ? 4'b0001 : 4'b0000)) begin
        n_fail++;
        $display("FAIL rmid_regrant[%0d]: got %b want %b", j, io_req_ready, (j == 1) ? 4'b0001 : 4'b0000);
      end
    end
    repeat (LATENCY + 1) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (io_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_err: got %b want 0", io_err);
    end
  endtask

  task automatic test_err;
    @(posedge clk); #1 force_yv = 1'b1;
    @(negedge clk);
    n_checks++;
    if (io_err !== 1'b0 || io_rsp_valid !== '0) begin
      n_fail++;
      $display("FAIL err_pre: err=%b rv=%b want 0/0", io_err, io_rsp_valid);
    end
    @(posedge clk); #1 force_yv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (io_err !== 1'b1) begin
        n_fail++;
        $display("FAIL err_sticky[%0d]: got %b want 1", k, io_err);
      end
    end
    @(posedge clk); #1 reset = 1'b0;
    #1;
    n_checks++;
    if (io_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %b want 0", io_err);
    end
    @(posedge clk); #1 reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_all4();
    test_sparse();
    test_flush();
    test_reset_mid();
    test_err();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
